// File: rtl/router_reg_p.sv
// Data/parity register stage between the router FSM and the output FIFOs.
// Forwards header and payload, buffers bytes while the FIFO is full, and checks the packet checksum.
module router_reg_p #(
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_DEPTH  = 2,
    parameter int PARITY_MODE = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  hold_empty,
    output logic                  hold_overflow,
    output logic                  low_packet_valid,
    output logic                  parity_done,
    output logic                  err
);
    localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int CNT_W = $clog2(HOLD_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(HOLD_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HOLD_DEPTH);

    function automatic logic [DATA_WIDTH-1:0] acc(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        if (PARITY_MODE == 1) begin
            acc = a + b;
        end else begin
            acc = a ^ b;
        end
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    logic [DATA_WIDTH-1:0] r_buf_data [HOLD_DEPTH];
    logic                  r_buf_par  [HOLD_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_header, r_int_par, r_pkt_par, r_dout;
    logic                  r_dout_valid, r_dout_par, r_drop_par;
    logic                  r_ovf, r_lpv, r_pdone, r_err;

    logic                  w_lfd, w_ld, w_laf;
    logic                  w_load, w_from_buf, w_push, w_pop, w_drop, w_done_trig;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic                  w_dpar_nxt;
    logic                  w_unused;

    // FIFO_FULL state needs no action here; the FSM uses hold_empty to leave LOAD_AFTER_FULL
    assign w_unused = full_state;

    assign w_lfd = lfd_state & ~detect_add;
    assign w_ld  = ld_state & ~detect_add & ~lfd_state;
    assign w_laf = laf_state & ~detect_add & ~lfd_state & ~ld_state;

    // Data-path decode: direct write, write-through-buffer, buffer push, or drop
    always_comb begin
        w_load     = 1'b0;
        w_from_buf = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_drop     = 1'b0;
        if (w_ld) begin
            if (!fifo_full) begin
                w_load = 1'b1;
                if (r_cnt != {CNT_W{1'b0}}) begin
                    w_from_buf = 1'b1;
                    w_pop      = 1'b1;
                    w_push     = 1'b1;
                end else begin
                    w_from_buf = 1'b0;
                end
            end else if (r_cnt != CNT_FULL) begin
                w_push = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end else if (w_laf) begin
            if (!fifo_full && (r_cnt != {CNT_W{1'b0}})) begin
                w_load     = 1'b1;
                w_from_buf = 1'b1;
                w_pop      = 1'b1;
            end else begin
                w_load = 1'b0;
            end
        end else if (w_lfd) begin
            w_load = 1'b1;
        end else begin
            w_load = 1'b0;
        end
    end

    // Select the byte (and its parity-byte tag) loaded into dout
    always_comb begin
        w_dout_nxt = data_in;
        w_dpar_nxt = ~pkt_valid;
        if (w_lfd) begin
            w_dout_nxt = r_header;
            w_dpar_nxt = 1'b0;
        end else if (w_from_buf) begin
            w_dout_nxt = r_buf_data[r_rd_ptr];
            w_dpar_nxt = r_buf_par[r_rd_ptr];
        end else begin
            w_dout_nxt = data_in;
            w_dpar_nxt = ~pkt_valid;
        end
    end

    assign w_done_trig = (r_dout_valid & r_dout_par) | r_drop_par;

    // Skid buffer storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HOLD_DEPTH; i++) begin
                r_buf_data[i] <= {DATA_WIDTH{1'b0}};
                r_buf_par[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_buf_data[r_wr_ptr] <= data_in;
            r_buf_par[r_wr_ptr]  <= ~pkt_valid;
        end
    end

    // Skid buffer pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else if (detect_add) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // FIFO write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dout       <= {DATA_WIDTH{1'b0}};
            r_dout_valid <= 1'b0;
            r_dout_par   <= 1'b0;
        end else if (w_load) begin
            r_dout       <= w_dout_nxt;
            r_dout_valid <= 1'b1;
            r_dout_par   <= w_dpar_nxt;
        end else begin
            r_dout_valid <= 1'b0;
        end
    end

    // Header capture and checksum accumulation; dropped payload still counts toward the checksum
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_header  <= {DATA_WIDTH{1'b0}};
            r_int_par <= {DATA_WIDTH{1'b0}};
            r_pkt_par <= {DATA_WIDTH{1'b0}};
        end else if (detect_add) begin
            if (pkt_valid) r_header <= data_in;
            r_int_par <= {DATA_WIDTH{1'b0}};
        end else if (w_lfd) begin
            r_int_par <= acc(r_int_par, r_header);
        end else if (w_ld && pkt_valid) begin
            r_int_par <= acc(r_int_par, data_in);
        end else if (w_ld) begin
            r_pkt_par <= data_in;
        end
    end

    // Packet status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf      <= 1'b0;
            r_lpv      <= 1'b0;
            r_drop_par <= 1'b0;
            r_pdone    <= 1'b0;
            r_err      <= 1'b0;
        end else if (detect_add) begin
            r_ovf      <= 1'b0;
            r_lpv      <= 1'b0;
            r_drop_par <= 1'b0;
            r_pdone    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_drop) r_ovf <= 1'b1;
            r_drop_par <= w_drop & ~pkt_valid;
            if (rst_int_reg) begin
                r_lpv <= 1'b0;
            end else if (w_ld && !pkt_valid) begin
                r_lpv <= 1'b1;
            end
            if (w_done_trig && !r_pdone) begin
                r_pdone <= 1'b1;
                r_err   <= (r_int_par != r_pkt_par) | r_ovf;
            end
        end
    end

    assign dout             = r_dout;
    assign dout_valid       = r_dout_valid;
    assign hold_empty       = (r_cnt == {CNT_W{1'b0}});
    assign hold_overflow    = r_ovf;
    assign low_packet_valid = r_lpv;
    assign parity_done      = r_pdone;
    assign err              = r_err;
endmodule

// File: tb/tb_router_reg_p.sv
// Directed and randomized bench for router_reg_p; expected byte streams and checksum
// verdicts come from a packet-level model of arrivals, buffer occupancy and drops.
module tb_router_reg_p;
    localparam int HD = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] data_in, dout;
    logic       dout_valid, hold_empty, hold_overflow, low_packet_valid, parity_done, err;

    logic        p16_pkt_valid, p16_fifo_full, p16_detect_add, p16_lfd, p16_ld, p16_laf;
    logic [15:0] p16_data_in, p16_dout;
    logic        p16_dout_valid, p16_hold_empty, p16_ovf, p16_lpv, p16_pdone, p16_err;

    router_reg_p #(.DATA_WIDTH(8), .HOLD_DEPTH(HD), .PARITY_MODE(0)) u_dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout), .dout_valid(dout_valid),
        .hold_empty(hold_empty), .hold_overflow(hold_overflow),
        .low_packet_valid(low_packet_valid), .parity_done(parity_done), .err(err));

    router_reg_p #(.DATA_WIDTH(16), .HOLD_DEPTH(2), .PARITY_MODE(1)) u_dut16 (
        .clock(clock), .reset(reset), .pkt_valid(p16_pkt_valid), .data_in(p16_data_in),
        .fifo_full(p16_fifo_full), .detect_add(p16_detect_add), .lfd_state(p16_lfd),
        .ld_state(p16_ld), .laf_state(p16_laf), .full_state(1'b0),
        .rst_int_reg(1'b0), .dout(p16_dout), .dout_valid(p16_dout_valid),
        .hold_empty(p16_hold_empty), .hold_overflow(p16_ovf),
        .low_packet_valid(p16_lpv), .parity_done(p16_pdone), .err(p16_err));

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [7:0] obs[$];
    logic [7:0] g_bytes[$];
    bit         g_full[$];
    int         g_laf_pct;

    // Every byte written to the FIFO port, in order
    always @(negedge clock) begin
        if (reset === 1'b0 && dout_valid === 1'b1) obs.push_back(dout);
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step(input bit da, input bit lf, input bit ld, input bit la,
                        input bit pv, input bit ff, input logic [7:0] d);
        detect_add = da; lfd_state = lf; ld_state = ld; laf_state = la;
        pkt_valid = pv; fifo_full = ff; data_in = d; rst_int_reg = 1'b0; full_state = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic step16(input bit da, input bit lf, input bit ld, input bit pv, input logic [15:0] d);
        p16_detect_add = da; p16_lfd = lf; p16_ld = ld; p16_laf = 1'b0;
        p16_pkt_valid = pv; p16_fifo_full = 1'b0; p16_data_in = d;
        @(posedge clock); #1;
    endtask

    // One packet: g_bytes holds payload then parity byte, g_full the FIFO state per byte
    task automatic run_pkt(input string tag, input logic [7:0] hdr);
        logic [7:0] exp_q[$];
        logic [7:0] calc;
        int occ, n;
        bit dropped, f, last, direct_par;
        n = g_bytes.size();
        calc = hdr; occ = 0; dropped = 1'b0; direct_par = 1'b0;
        exp_q.push_back(hdr);
        obs.delete();
        step(1, 0, 0, 0, 1, 0, hdr);
        check({tag, "_da_pdone"}, parity_done, 0);
        check({tag, "_da_err"}, err, 0);
        check({tag, "_da_ovf"}, hold_overflow, 0);
        check({tag, "_da_empty"}, hold_empty, 1);
        step(0, 1, 0, 0, 1, 0, 8'h00);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            f = g_full[i];
            if (!last) calc ^= g_bytes[i];
            if (f && occ == HD) dropped = 1'b1;
            else exp_q.push_back(g_bytes[i]);
            if (f && occ < HD) occ++;
            direct_par = last && !f && (occ == 0);
            step(0, 0, 1, 0, !last, f, g_bytes[i]);
        end
        if (direct_par) begin
            check({tag, "_par_dout"}, dout, g_bytes[n-1]);
            check({tag, "_par_dv"}, dout_valid, 1);
            check({tag, "_par_pdone_early"}, parity_done, 0);
        end
        for (int k = 0; k < 40 && occ > 0; k++) begin
            f = (k < 20) && ($urandom_range(99) < g_laf_pct);
            check({tag, "_laf_empty"}, hold_empty, 0);
            step(0, 0, 0, 1, 0, f, 8'h00);
            if (!f) occ--;
        end
        step(0, 0, 0, 0, 0, 0, 8'h00);
        if (direct_par) check({tag, "_pdone_next"}, parity_done, 1);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        check({tag, "_nbytes"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check({tag, "_byte"}, obs[i], exp_q[i]);
        check({tag, "_empty"}, hold_empty, 1);
        check({tag, "_pdone"}, parity_done, 1);
        check({tag, "_err"}, err, (calc != g_bytes[n-1]) || dropped);
        check({tag, "_ovf"}, hold_overflow, dropped);
        check({tag, "_lpv"}, low_packet_valid, 1);
        rst_int_reg = 1'b1;
        @(posedge clock); #1;
        rst_int_reg = 1'b0;
        check({tag, "_lpv_clr"}, low_packet_valid, 0);
        check({tag, "_pdone_hold"}, parity_done, 1);
    endtask

    task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input int n, input bit f0, input bit f1, input bit f2);
        logic [7:0] bb[4];
        bit ff[3];
        bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
        ff[0] = f0; ff[1] = f1; ff[2] = f2;
        g_bytes.delete(); g_full.delete();
        for (int i = 0; i < n; i++) begin
            g_bytes.push_back(bb[i]);
            g_full.push_back((i < 3) ? ff[i] : 1'b0);
        end
    endtask

    initial begin
        logic [7:0] hdr, x, b;
        int n;
        step(0, 0, 0, 0, 0, 0, 8'h00);
        step16(0, 0, 0, 0, 16'h0000);
        check("rst_dout", dout, 0);
        check("rst_dv", dout_valid, 0);
        check("rst_empty", hold_empty, 1);
        check("rst_pdone", parity_done, 0);
        check("rst_err", err, 0);
        check("rst_lpv", low_packet_valid, 0);
        check("rst_empty16", p16_hold_empty, 1);
        reset = 1'b0;
        g_laf_pct = 0;

        load(8'h11, 8'h22, 8'h36, 8'h00, 3, 0, 0, 0);
        run_pkt("t1", 8'h05);
        load(8'h11, 8'h22, 8'h37, 8'h00, 3, 0, 0, 0);
        run_pkt("t2", 8'h05);
        load(8'h11, 8'h22, 8'h33, 8'h05, 4, 0, 1, 1);
        run_pkt("t3", 8'h05);
        load(8'h11, 8'h22, 8'h33, 8'h05, 4, 1, 1, 1);
        run_pkt("t4", 8'h05);

        // Wrap-around additive checksum on the 16-bit instance
        step16(1, 0, 0, 1, 16'hFFFF);
        step16(0, 1, 0, 1, 16'h0000);
        check("t5_hdr", p16_dout, 16'hFFFF);
        step16(0, 0, 1, 1, 16'h0002);
        step16(0, 0, 1, 0, 16'h0001);
        step16(0, 0, 0, 0, 16'h0000);
        step16(0, 0, 0, 0, 16'h0000);
        check("t5_pdone", p16_pdone, 1);
        check("t5_err", p16_err, 0);
        check("t5_dout", p16_dout, 16'h0001);
        step16(1, 0, 0, 1, 16'h8000);
        step16(0, 1, 0, 1, 16'h0000);
        step16(0, 0, 1, 1, 16'h8001);
        step16(0, 0, 1, 0, 16'h0002);
        step16(0, 0, 0, 0, 16'h0000);
        step16(0, 0, 0, 0, 16'h0000);
        check("t5b_err", p16_err, 1);

        // Asynchronous reset mid-packet with one byte held
        step(1, 0, 0, 0, 1, 0, 8'h05);
        step(0, 1, 0, 0, 1, 0, 8'h00);
        step(0, 0, 1, 0, 1, 1, 8'h11);
        check("t6_held", hold_empty, 0);
        #3 reset = 1'b1;
        #1;
        check("t6_dout", dout, 0);
        check("t6_dv", dout_valid, 0);
        check("t6_empty", hold_empty, 1);
        check("t6_ovf", hold_overflow, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        load(8'h11, 8'h22, 8'h36, 8'h00, 3, 0, 0, 0);
        run_pkt("t6_next", 8'h05);

        // Randomized packets
        g_laf_pct = 30;
        for (int p = 0; p < 10; p++) begin
            hdr = 8'($urandom);
            x = hdr;
            n = $urandom_range(1, 6);
            g_bytes.delete(); g_full.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                x ^= b;
                g_bytes.push_back(b);
                g_full.push_back($urandom_range(99) < 45);
            end
            if ($urandom_range(3) == 0) x ^= 8'h40;
            g_bytes.push_back(x);
            g_full.push_back($urandom_range(99) < 45);
            run_pkt("rnd", hdr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/router_reg_p.md
Name: router_reg_p

Overview:
Parametrised successor to the 1x3 router's data/parity register stage. It sits between the router FSM and the output FIFOs. It captures the header, forwards the header and payload to the FIFO write bus, and checks the packet parity. Compared with the current stage it adds:
- a configurable data width;
- a HOLD_DEPTH-entry skid buffer that preserves byte order while the FIFO is full;
- a selectable XOR or additive checksum;
- an explicit dout_valid strobe and an overflow flag.

Parameters:
DATA_WIDTH, 8, width of data_in, dout and all parity registers.
HOLD_DEPTH, 2, entries in the full-state skid buffer (at least 1).
PARITY_MODE, 0, 0 = bitwise XOR accumulate; 1 = sum modulo 2^DATA_WIDTH.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
pkt_valid  in  1  source packet valid; low marks the parity byte.
data_in  in  DATA_WIDTH  source byte.
fifo_full  in  1  selected output FIFO full.
detect_add  in  1  FSM in DECODE_ADDRESS state.
lfd_state  in  1  FSM in LOAD_FIRST_DATA state.
ld_state  in  1  FSM in LOAD_DATA state.
laf_state  in  1  FSM in LOAD_AFTER_FULL state.
full_state  in  1  FSM in FIFO_FULL state; no register action of its own.
rst_int_reg  in  1  clears low_packet_valid.
dout  out  DATA_WIDTH  byte to FIFO write port.
dout_valid  out  1  dout was loaded this cycle (write enable).
hold_empty  out  1  skid buffer empty (combinational from the count).
hold_overflow  out  1  sticky: a byte was dropped because the buffer was full.
low_packet_valid  out  1  parity byte received.
parity_done  out  1  parity byte has been written to dout.
err  out  1  checksum mismatch.

Behaviour:
- Reset (async, active-high) clears every output, header, internal_parity, packet_parity, buffer pointers and count. hold_empty=1 during and after reset.
- State-input priority when several are high: detect_add > lfd_state > ld_state > laf_state.
- detect_add:
  - Captures header=data_in if pkt_valid.
  - Clears internal_parity (0 in both modes), parity_done, err, low_packet_valid, hold_overflow and the buffer count/pointers.
  - dout_valid=0.
- lfd_state: dout<=header, dout_valid=1. internal_parity<=acc(internal_parity, header).
- ld_state, with B = buffer count:
  - fifo_full=0, B=0: dout<=data_in, dout_valid=1.
  - fifo_full=0, B>0: dout<=buffer head (pop) and data_in pushed in the same cycle. Order is preserved and B is unchanged.
  - fifo_full=1, B<HOLD_DEPTH: push data_in, B+1, dout_valid=0.
  - fifo_full=1, B=HOLD_DEPTH: data_in dropped, hold_overflow<=1, dout_valid=0.
- laf_state:
  - fifo_full=0 and B>0: dout<=head, pop, dout_valid=1.
  - Otherwise dout_valid=0, dout holds.
- No state input high: dout holds, dout_valid=0.
- Payload parity: in ld_state with pkt_valid=1, internal_parity<=acc(internal_parity, data_in). This applies whether the byte is written, buffered or dropped.
- Accumulate function acc: XOR (PARITY_MODE 0) or unsigned wrap-around add (PARITY_MODE 1).
- Parity byte: in ld_state with pkt_valid=0:
  - packet_parity<=data_in and low_packet_valid<=1.
  - The byte travels through the same dout/buffer path as payload but is not accumulated.
- low_packet_valid is cleared by rst_int_reg or detect_add.
- parity_done:
  - Set on the edge after the cycle in which the parity byte is driven onto dout with dout_valid=1 (directly or by drain).
  - Holds until detect_add.
  - If the parity byte was dropped (overflow), parity_done is set on the edge after the parity byte was received.
- err:
  - Updated on the same edge parity_done rises: err<=(internal_parity != packet_parity) OR hold_overflow.
  - Otherwise holds until detect_add.
- Buffer pointers wrap modulo HOLD_DEPTH. The count never exceeds HOLD_DEPTH.
- hold_empty = (B==0). The FSM leaves LOAD_AFTER_FULL only when hold_empty=1.

Test Plan:
1. W=8, XOR, header 0x05, payload 0x11,0x22, parity 0x36, fifo_full=0 throughout -> dout sequence 0x05,0x11,0x22,0x36 with dout_valid each cycle. parity_done=1 one cycle after 0x36. err=0.
2. Same packet with parity byte 0x37 -> parity_done=1, err=1. The next detect_add clears both to 0.
3. HOLD_DEPTH=2, fifo_full=1 during payload bytes 0x22,0x33, then fifo_full=0 in laf_state -> 0x22 then 0x33 on consecutive cycles. hold_empty returns to 1. No byte loss or reorder.
4. fifo_full=1 for 3 ld bytes with HOLD_DEPTH=2 -> third byte dropped, hold_overflow=1, and at parity_done err=1 even with a correct checksum.
5. PARITY_MODE=1, W=16, header 0xFFFF, payload 0x0002, parity 0x0001 -> err=0 (wrap-around sum).
6. Assert reset mid-packet with B=1 -> all outputs 0 immediately (async), hold_empty=1. The next packet is processed as in test 1.
